// File: rtl/z_display_driver.sv
// Two-digit multiplexed 7-segment driver for the 4-bit mode counter value Z.
// Leading zero is suppressed and the ones-digit dp marks odd values.
module z_display_driver #(
    parameter int REFRESH_DIV    = 4,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Z,
    input  logic       blank,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic       dp
);

    localparam int            CW      = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);

    // Segment patterns are built active-low, then flipped once for polarity.
    localparam logic [6:0] SEG_OFF_AL = 7'h7F;
    localparam logic       DP_OFF_AL  = 1'b1;
    localparam logic [6:0] SEG_OFF    = SEG_ACTIVE_LOW ? SEG_OFF_AL : ~SEG_OFF_AL;
    localparam logic       DP_OFF     = SEG_ACTIVE_LOW ? DP_OFF_AL : ~DP_OFF_AL;

    typedef struct packed {
        logic [6:0] seg;
        logic [1:0] an;
        logic       dp;
    } disp_t;

    function automatic logic [6:0] encode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    logic [3:0]    z_q;
    logic [CW-1:0] scan_cnt;
    logic          digit_sel;

    logic          tens;
    logic [3:0]    ones;
    disp_t         raw;
    disp_t         disp_nxt;

    always_comb begin
        tens = (z_q >= 4'd10);
        ones = z_q - (tens ? 4'd10 : 4'd0);
    end

    always_comb begin
        raw = '{seg: SEG_OFF_AL, an: 2'b11, dp: DP_OFF_AL};
        if (!blank) begin
            if (!digit_sel) begin
                raw.an  = 2'b10;
                raw.seg = encode(ones);
                raw.dp  = ~z_q[0];
            end else if (tens) begin
                raw.an  = 2'b01;
                raw.seg = encode(4'd1);
            end
        end
        disp_nxt     = raw;
        disp_nxt.seg = SEG_ACTIVE_LOW ? raw.seg : ~raw.seg;
        disp_nxt.dp  = SEG_ACTIVE_LOW ? raw.dp : ~raw.dp;
    end

    // Scan keeps running through blank so the phase never drifts.
    always_ff @(posedge clk) begin
        if (reset) begin
            z_q       <= '0;
            scan_cnt  <= '0;
            digit_sel <= 1'b0;
            seg       <= SEG_OFF;
            an        <= 2'b11;
            dp        <= DP_OFF;
        end else begin
            z_q <= Z;
            if (scan_cnt == CNT_MAX) begin
                scan_cnt  <= '0;
                digit_sel <= ~digit_sel;
            end else begin
                scan_cnt <= scan_cnt + CW'(1);
            end
            seg <= disp_nxt.seg;
            an  <= disp_nxt.an;
            dp  <= disp_nxt.dp;
        end
    end

endmodule

// File: tb/tb_z_display_driver.sv
// Directed bench for z_display_driver: both segment polarities, REFRESH_DIV=4.
module tb_z_display_driver;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] Z;
    logic       blank;
    logic [6:0] seg,   seg_h;
    logic [1:0] an,    an_h;
    logic       dp,    dp_h;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    z_display_driver #(.REFRESH_DIV(4), .SEG_ACTIVE_LOW(1'b1)) dut (
        .clk(clk), .reset(reset), .Z(Z), .blank(blank),
        .seg(seg), .an(an), .dp(dp)
    );

    z_display_driver #(.REFRESH_DIV(4), .SEG_ACTIVE_LOW(1'b0)) dut_hi (
        .clk(clk), .reset(reset), .Z(Z), .blank(blank),
        .seg(seg_h), .an(an_h), .dp(dp_h)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // After return the next tick is edge 1; edges 1-4 ones phase, 5-8 tens, ...
    task automatic do_reset(input logic [3:0] z);
        reset = 1'b1;
        blank = 1'b0;
        Z     = z;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        blank = 1'b0;
        Z     = 4'd5;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({seg, an, dp} !== {7'h7F, 2'b11, 1'b1}) begin
                errors++;
                $display("FAIL reset_hold[%0d]: got seg=%h an=%b dp=%b want seg=7f an=11 dp=1", i, seg, an, dp);
            end
        end
        reset = 1'b0;
        tick();
        checks++;
        if ({seg, an, dp} !== {7'h40, 2'b10, 1'b1}) begin
            errors++;
            $display("FAIL reset_edge1: got seg=%h an=%b dp=%b want seg=40 an=10 dp=1", seg, an, dp);
        end
        tick();
        checks++;
        if ({seg, an, dp} !== {7'h12, 2'b10, 1'b0}) begin
            errors++;
            $display("FAIL reset_first_ones: got seg=%h an=%b dp=%b want seg=12 an=10 dp=0", seg, an, dp);
        end
    endtask

    task automatic test_odd_single();
        logic [6:0] es;
        logic [1:0] ea;
        logic       ed;
        do_reset(4'd7);
        tick();
        for (int n = 2; n <= 16; n++) begin
            tick();
            if (((n - 1) / 4) % 2 == 0) begin
                es = 7'h78; ea = 2'b10; ed = 1'b0;
            end else begin
                es = 7'h7F; ea = 2'b11; ed = 1'b1;
            end
            checks++;
            if ({seg, an, dp} !== {es, ea, ed}) begin
                errors++;
                $display("FAIL odd7_edge%0d: got seg=%h an=%b dp=%b want seg=%h an=%b dp=%b", n, seg, an, dp, es, ea, ed);
            end
        end
    endtask

    task automatic test_two_digit_even();
        logic [6:0] es;
        logic [1:0] ea;
        do_reset(4'd14);
        tick();
        for (int n = 2; n <= 12; n++) begin
            tick();
            if (((n - 1) / 4) % 2 == 0) begin
                es = 7'h19; ea = 2'b10;
            end else begin
                es = 7'h79; ea = 2'b01;
            end
            checks++;
            if ({seg, an, dp} !== {es, ea, 1'b1}) begin
                errors++;
                $display("FAIL even14_edge%0d: got seg=%h an=%b dp=%b want seg=%h an=%b dp=1", n, seg, an, dp, es, ea);
            end
        end
    endtask

    task automatic test_boundary_wrap();
        logic [3:0] zv   [4] = '{4'd9, 4'd10, 4'd15, 4'd1};
        logic [6:0] oseg [4] = '{7'h10, 7'h40, 7'h12, 7'h79};
        logic       odp  [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic [6:0] tseg [4] = '{7'h7F, 7'h79, 7'h79, 7'h7F};
        logic [1:0] tan  [4] = '{2'b11, 2'b01, 2'b01, 2'b11};
        do_reset(4'd9);
        for (int s = 0; s < 4; s++) begin
            Z = zv[s];
            tick();
            for (int j = 0; j < 3; j++) begin
                tick();
                checks++;
                if ({seg, an, dp} !== {oseg[s], 2'b10, odp[s]}) begin
                    errors++;
                    $display("FAIL wrap_z%0d_ones%0d: got seg=%h an=%b dp=%b want seg=%h an=10 dp=%b",
                             zv[s], j, seg, an, dp, oseg[s], odp[s]);
                end
            end
            for (int j = 0; j < 4; j++) begin
                tick();
                checks++;
                if ({seg, an, dp} !== {tseg[s], tan[s], 1'b1}) begin
                    errors++;
                    $display("FAIL wrap_z%0d_tens%0d: got seg=%h an=%b dp=%b want seg=%h an=%b dp=1",
                             zv[s], j, seg, an, dp, tseg[s], tan[s]);
                end
            end
        end
    endtask

    task automatic test_blank_and_reset();
        logic [6:0] es [3] = '{7'h24, 7'h24, 7'h79};
        logic [1:0] ea [3] = '{2'b10, 2'b10, 2'b01};
        do_reset(4'd12);
        for (int n = 1; n <= 4; n++) tick();
        checks++;
        if ({seg, an, dp} !== {7'h24, 2'b10, 1'b1}) begin
            errors++;
            $display("FAIL blank_pre: got seg=%h an=%b dp=%b want seg=24 an=10 dp=1", seg, an, dp);
        end
        blank = 1'b1;
        for (int n = 5; n <= 10; n++) begin
            tick();
            checks++;
            if ({seg, an, dp} !== {7'h7F, 2'b11, 1'b1}) begin
                errors++;
                $display("FAIL blank_edge%0d: got seg=%h an=%b dp=%b want seg=7f an=11 dp=1", n, seg, an, dp);
            end
        end
        blank = 1'b0;
        for (int n = 11; n <= 13; n++) begin
            tick();
            checks++;
            if ({seg, an, dp} !== {es[n-11], ea[n-11], 1'b1}) begin
                errors++;
                $display("FAIL unblank_edge%0d: got seg=%h an=%b dp=%b want seg=%h an=%b dp=1",
                         n, seg, an, dp, es[n-11], ea[n-11]);
            end
        end
        tick();
        reset = 1'b1;
        tick();
        checks++;
        if ({seg, an, dp} !== {7'h7F, 2'b11, 1'b1}) begin
            errors++;
            $display("FAIL midscan_reset: got seg=%h an=%b dp=%b want seg=7f an=11 dp=1", seg, an, dp);
        end
        reset = 1'b0;
        tick();
        checks++;
        if ({seg, an, dp} !== {7'h40, 2'b10, 1'b1}) begin
            errors++;
            $display("FAIL post_reset_sel0: got seg=%h an=%b dp=%b want seg=40 an=10 dp=1", seg, an, dp);
        end
        tick();
        checks++;
        if ({seg, an, dp} !== {7'h24, 2'b10, 1'b1}) begin
            errors++;
            $display("FAIL post_reset_ones: got seg=%h an=%b dp=%b want seg=24 an=10 dp=1", seg, an, dp);
        end
    endtask

    task automatic test_polarity();
        reset = 1'b1;
        blank = 1'b0;
        Z     = 4'd8;
        tick();
        checks++;
        if ({seg_h, an_h, dp_h} !== {7'h00, 2'b11, 1'b0}) begin
            errors++;
            $display("FAIL hi_reset: got seg=%h an=%b dp=%b want seg=00 an=11 dp=0", seg_h, an_h, dp_h);
        end
        tick();
        reset = 1'b0;
        tick();
        for (int n = 2; n <= 8; n++) begin
            tick();
            checks++;
            if (n <= 4) begin
                if ({seg_h, an_h, dp_h} !== {7'h7F, 2'b10, 1'b0}) begin
                    errors++;
                    $display("FAIL hi_ones_edge%0d: got seg=%h an=%b dp=%b want seg=7f an=10 dp=0", n, seg_h, an_h, dp_h);
                end
            end else begin
                if ({seg_h, an_h, dp_h} !== {7'h00, 2'b11, 1'b0}) begin
                    errors++;
                    $display("FAIL hi_tens_edge%0d: got seg=%h an=%b dp=%b want seg=00 an=11 dp=0", n, seg_h, an_h, dp_h);
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        blank = 1'b0;
        Z     = 4'd0;
        test_reset();
        test_odd_single();
        test_two_digit_even();
        test_boundary_wrap();
        test_blank_and_reset();
        test_polarity();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
